// File: rtl/i2c_cmd_arbiter_if.sv
// Requester and I2C_Controller signal bundle for i2c_cmd_arbiter.
// master = requesters/controller side, slave = arbiter side.
interface i2c_cmd_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req;
  logic [24*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic                  done_err;
  logic                  busy;
  logic [23:0]           ctrl_data;
  logic                  ctrl_go;
  logic                  ctrl_end;
  logic                  ctrl_ack;

  modport master (
    output req, req_data,
    output ctrl_end, ctrl_ack,
    input  grant, done, done_err, busy,
    input  ctrl_data, ctrl_go
  );

  modport slave (
    input  req, req_data,
    input  ctrl_end, ctrl_ack,
    output grant, done, done_err, busy,
    output ctrl_data, ctrl_go
  );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C_Controller among NUM_REQ requesters,
// with NACK/timeout retry and per-requester done/err status.
module i2c_cmd_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 200000
) (
  input logic CLOCK_50,
  input logic iRST_N,
  i2c_cmd_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW =
    (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RTY_LAST = RW'(MAX_RETRY);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);
  localparam logic [IW:0]   NREQ_W   = (IW+1)'(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_GO,
    S_WAIT_END,
    S_RELEASE,
    S_WAIT_LOW,
    S_RETIRE
  } state_t;

  state_t               r_state;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_idx;
  logic [TW-1:0]        r_tmo;
  logic [RW-1:0]        r_retry;
  logic                 r_fail;
  logic                 r_end_m, r_end_s;
  logic                 r_ack_m, r_ack_s;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_done_err;
  logic                 r_busy;
  logic                 r_go;
  logic [23:0]          r_data;

  logic                 w_hit;
  logic [IW-1:0]        w_win;
  logic [IW:0]          w_sum;
  logic                 w_fail;

  // First set request at or above the pointer, wrapping at NUM_REQ.
  always_comb begin
    w_hit = 1'b0;
    w_win = '0;
    w_sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_sum >= NREQ_W)
        w_sum = w_sum - NREQ_W;
      if (!w_hit && bus.req[w_sum[IW-1:0]]) begin
        w_hit = 1'b1;
        w_win = w_sum[IW-1:0];
      end
    end
  end

  // END still high after the wait-low bound means the attempt failed.
  assign w_fail = r_fail | r_end_s;

  always_ff @(posedge CLOCK_50) begin
    if (!iRST_N) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_tmo      <= '0;
      r_retry    <= '0;
      r_fail     <= 1'b0;
      r_end_m    <= 1'b0;
      r_end_s    <= 1'b0;
      r_ack_m    <= 1'b0;
      r_ack_s    <= 1'b0;
      r_grant    <= '0;
      r_done     <= '0;
      r_done_err <= 1'b0;
      r_busy     <= 1'b0;
      r_go       <= 1'b0;
      r_data     <= 24'h0;
    end else begin
      r_end_m <= bus.ctrl_end;
      r_end_s <= r_end_m;
      r_ack_m <= bus.ctrl_ack;
      r_ack_s <= r_ack_m;
      unique case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_idx          <= w_win;
            r_grant        <= '0;
            r_grant[w_win] <= 1'b1;
            r_busy         <= 1'b1;
            r_state        <= S_LATCH;
          end
        end
        S_LATCH: begin
          r_data  <= bus.req_data[24*r_idx +: 24];
          r_retry <= '0;
          r_state <= S_GO;
        end
        S_GO: begin
          r_go    <= 1'b1;
          r_tmo   <= '0;
          r_state <= S_WAIT_END;
        end
        S_WAIT_END: begin
          r_tmo <= r_tmo + 1'b1;
          if (r_end_s) begin
            r_fail  <= r_ack_s;
            r_go    <= 1'b0;
            r_state <= S_RELEASE;
          end else if (r_tmo == TMO_LAST) begin
            r_fail  <= 1'b1;
            r_go    <= 1'b0;
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          r_go    <= 1'b0;
          r_tmo   <= '0;
          r_state <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          r_tmo <= r_tmo + 1'b1;
          if (!r_end_s || r_tmo == TMO_LAST) begin
            if (!w_fail) begin
              r_done     <= r_grant;
              r_done_err <= 1'b0;
              r_state    <= S_RETIRE;
            end else if (r_retry != RTY_LAST) begin
              r_retry <= r_retry + 1'b1;
              r_state <= S_GO;
            end else begin
              r_done     <= r_grant;
              r_done_err <= 1'b1;
              r_state    <= S_RETIRE;
            end
          end
        end
        S_RETIRE: begin
          r_done     <= '0;
          r_done_err <= 1'b0;
          r_grant    <= '0;
          r_busy     <= 1'b0;
          r_ptr      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.done      = r_done;
  assign bus.done_err  = r_done_err;
  assign bus.busy      = r_busy;
  assign bus.ctrl_data = r_data;
  assign bus.ctrl_go   = r_go;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter with a behavioural I2C_Controller
// responder (delay, NACK count, never-END mode).
module tb_i2c_cmd_arbiter;

  localparam int N = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  i2c_cmd_arbiter_if #(.NUM_REQ(N)) bus ();

  i2c_cmd_arbiter #(
    .NUM_REQ  (N),
    .MAX_RETRY(3),
    .TIMEOUT  (1000)
  ) dut (
    .CLOCK_50(clk),
    .iRST_N  (rst_n),
    .bus     (bus)
  );

  int     n_chk = 0;
  int     n_fail = 0;
  longint cyc = 0;
  int     resp_dly = 40;
  int     nack_left = 0;
  bit     never_end = 1'b0;
  int     go_rises = 0;
  int     go_len = 0;
  longint go_rise_cyc = 0;
  bit     go_prev = 1'b0;
  int     viol = 0;

  logic [N-1:0] done_q[$];
  logic         err_q[$];
  logic [23:0]  data_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (bus.ctrl_go && !go_prev) begin
      go_rises++;
      go_rise_cyc = cyc;
      data_q.push_back(bus.ctrl_data);
    end
    if (!bus.ctrl_go && go_prev)
      go_len = int'(cyc - go_rise_cyc);
    if (bus.ctrl_go && !$onehot(bus.grant))
      viol++;
    go_prev = bus.ctrl_go;
    if (|bus.done) begin
      done_q.push_back(bus.done);
      err_q.push_back(bus.done_err);
    end
  end

  // Controller model: END (with ACK) after resp_dly, cleared after GO drops.
  initial begin
    bus.ctrl_end = 1'b0;
    bus.ctrl_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.ctrl_go) begin
        if (!never_end) begin
          repeat (resp_dly) begin @(posedge clk); #1; end
          bus.ctrl_ack = (nack_left > 0);
          if (nack_left > 0) nack_left--;
          bus.ctrl_end = 1'b1;
        end
        while (bus.ctrl_go) begin @(posedge clk); #1; end
        repeat (2) begin @(posedge clk); #1; end
        bus.ctrl_end = 1'b0;
        bus.ctrl_ack = 1'b0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    done_q.delete();
    err_q.delete();
    data_q.delete();
    go_rises = 0;
    go_len = 0;
    viol = 0;
  endtask

  task automatic wait_done(input string tag, input int n, input int budget);
    int t;
    t = 0;
    while (done_q.size() < n && t < budget) begin
      tick();
      t++;
    end
    chk(tag, done_q.size(), n);
  endtask

  task automatic wait_go(input string tag, input int n, input int budget);
    int t;
    t = 0;
    while (go_rises < n && t < budget) begin
      tick();
      t++;
    end
    chk(tag, go_rises, n);
  endtask

  initial begin
    bus.req      = '0;
    bus.req_data = {24'hCC0003, 24'hBB0002, 24'h341E00};

    // reset state
    do_reset();
    chk("rst_grant", bus.grant, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.done_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_go", bus.ctrl_go, 0);
    chk("rst_data", bus.ctrl_data, 0);

    // single request, ACK after 40 cycles
    resp_dly = 40;
    bus.req = 3'b001;
    wait_done("t1_done_cnt", 1, 400);
    bus.req = '0;
    chk("t1_done", done_q[0], 3'b001);
    chk("t1_err", err_q[0], 0);
    chk("t1_data", bus.ctrl_data, 24'h341E00);
    chk("t1_go_cnt", go_rises, 1);
    chk("t1_busy_in_done", bus.busy, 1);
    tick();
    chk("t1_busy_after", bus.busy, 0);
    chk("t1_grant_after", bus.grant, 0);
    chk("t1_done_pulse", bus.done, 0);

    // all requesting: round-robin 0,1,2,0
    do_reset();
    resp_dly = 5;
    bus.req = 3'b111;
    wait_done("t2_done_cnt", 4, 1000);
    bus.req = '0;
    chk("t2_g0", done_q[0], 3'b001);
    chk("t2_g1", done_q[1], 3'b010);
    chk("t2_g2", done_q[2], 3'b100);
    chk("t2_g3", done_q[3], 3'b001);
    chk("t2_d1", data_q[1], 24'hBB0002);
    chk("t2_d2", data_q[2], 24'hCC0003);
    chk("t2_go_cnt", go_rises, 4);
    chk("t2_overlap", viol, 0);

    // NACK every attempt: 1 + 3 retries
    do_reset();
    nack_left = 100;
    bus.req = 3'b010;
    wait_done("t3_done_cnt", 1, 1000);
    bus.req = '0;
    nack_left = 0;
    chk("t3_done", done_q[0], 3'b010);
    chk("t3_err", err_q[0], 1);
    chk("t3_go_cnt", go_rises, 4);
    chk("t3_data", data_q[3], 24'hCC0002 ^ 24'h770000);

    // END never arrives: each GO lasts TIMEOUT cycles
    do_reset();
    never_end = 1'b1;
    bus.req = 3'b100;
    wait_done("t4_done_cnt", 1, 6000);
    bus.req = '0;
    never_end = 1'b0;
    chk("t4_done", done_q[0], 3'b100);
    chk("t4_err", err_q[0], 1);
    chk("t4_go_cnt", go_rises, 4);
    chk("t4_go_len", go_len, 1000);

    // NACK once then ACK, request dropped mid-transfer
    do_reset();
    nack_left = 1;
    resp_dly = 20;
    bus.req = 3'b010;
    wait_go("t5_go_seen", 1, 100);
    tick(5);
    bus.req = '0;
    wait_done("t5_done_cnt", 1, 500);
    chk("t5_done", done_q[0], 3'b010);
    chk("t5_err", err_q[0], 0);
    chk("t5_go_cnt", go_rises, 2);

    // reset during WAIT_END
    do_reset();
    resp_dly = 5;
    bus.req = 3'b001;
    wait_done("t6_pre_done", 1, 200);
    bus.req = '0;
    tick(2);
    never_end = 1'b1;
    bus.req = 3'b010;
    wait_go("t6_go_seen", 2, 100);
    tick(10);
    rst_n = 1'b0;
    tick();
    chk("t6_go_rst", bus.ctrl_go, 0);
    chk("t6_grant_rst", bus.grant, 0);
    chk("t6_busy_rst", bus.busy, 0);
    rst_n = 1'b1;
    bus.req = '0;
    never_end = 1'b0;
    tick(10);
    chk("t6_no_done", done_q.size(), 1);
    bus.req = 3'b101;
    tick();
    chk("t6_ptr_zero", bus.grant, 3'b001);
    wait_done("t6_post_done", 2, 300);
    bus.req = '0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
